fb_scanout: RTL

//  Video scan-out and SRAM arbiter for the 1bpp framebuffer held in the as7c256 SRAM.

---
 rtl/fb_scanout.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// Video scan-out for a 1bpp SRAM framebuffer, with CPU accesses slotted into
// cycles that carry no video fetch. Drives SRAM control and the bus-switch selects.
module fb_scanout #(
    parameter int          H_ACTIVE  = 256,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 32,
    parameter int          H_BP      = 16,
    parameter int          V_ACTIVE  = 240,
    parameter int          V_FP      = 3,
    parameter int          V_SYNC    = 4,
    parameter int          V_BP      = 15,
    parameter bit          SYNC_POL  = 1'b0,
    parameter logic [14:0] BASE_ADDR = 15'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel,
    output logic [14:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        vid_sel_n,
    output logic        cpu_sel_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack
);

    // state  | meaning
    // IDLE   | SRAM free for video; waiting for a request with a two-cycle fetch-free window
    // ADDR   | CPU address on SRAM, CPU path selected, output enabled on reads
    // STROBE | write strobe on writes; read data captured at the closing edge
    // ACK    | cpu_ack high, SRAM idle
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_ACK} state_t;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [14:0]   ROW_STEP = 15'(H_ACTIVE / 8);

    state_t        state;
    logic [HW-1:0] hcnt, h1, h2;
    logic [VW-1:0] vcnt, v1, v2;
    logic [14:0]   row_base;
    logic [14:0]   addr_hold;
    logic [7:0]    shreg;
    logic          vid_cond, hs_cond, vs_cond;
    logic          fetch_now, cpu_free, cpu_bus;

    function automatic logic fetch_at(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE) && (h[2:0] == 3'd0);
    endfunction

    // Raster positions one and two cycles ahead, for the CPU admission window.
    always_comb begin
        h1 = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
        v1 = vcnt;
        if (hcnt == H_LAST)
            v1 = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        h2 = (h1 == H_LAST) ? '0 : h1 + HW'(1);
        v2 = v1;
        if (h1 == H_LAST)
            v2 = (v1 == V_LAST) ? '0 : v1 + VW'(1);
    end

    assign vid_cond  = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    assign hs_cond   = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END);
    assign vs_cond   = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END);
    assign fetch_now = fetch_at(hcnt, vcnt) && !rst;
    assign cpu_free  = !fetch_at(h1, v1) && !fetch_at(h2, v2);
    assign cpu_bus   = (state == S_ADDR) || (state == S_STROBE);

    // SRAM side decodes straight from registered state so the async SRAM
    // returns fetch data within the fetch cycle itself.
    always_comb begin
        mem_addr  = addr_hold;
        vid_sel_n = 1'b1;
        cpu_sel_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        if (fetch_now) begin
            mem_addr  = row_base + 15'(hcnt[HW-1:3]);
            vid_sel_n = 1'b0;
            sram_oe_n = 1'b0;
        end else if (cpu_bus) begin
            mem_addr  = cpu_addr;
            cpu_sel_n = 1'b0;
            sram_oe_n = cpu_we;
            sram_we_n = (state == S_STROBE) ? ~cpu_we : 1'b1;
        end
    end

    assign mem_wdata = cpu_wdata;
    assign pixel     = shreg[7] & de;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            row_base  <= BASE_ADDR;
            addr_hold <= BASE_ADDR;
            shreg     <= '0;
            de        <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            state     <= S_IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            hcnt      <= h1;
            vcnt      <= v1;
            addr_hold <= mem_addr;
            de        <= vid_cond;
            hsync     <= hs_cond ? SYNC_POL : ~SYNC_POL;
            vsync     <= vs_cond ? SYNC_POL : ~SYNC_POL;
            shreg     <= fetch_now ? mem_rdata : {shreg[6:0], 1'b0};

            if (hcnt == H_LAST) begin
                if (vcnt == V_LAST)
                    row_base <= BASE_ADDR;
                else if (int'(vcnt) < V_ACTIVE)
                    row_base <= row_base + ROW_STEP;
            end

            case (state)
                S_IDLE: begin
                    cpu_ack <= 1'b0;
                    if (cpu_req && cpu_free)
                        state <= S_ADDR;
                end
                S_ADDR: state <= S_STROBE;
                S_STROBE: begin
                    if (!cpu_we)
                        cpu_rdata <= mem_rdata;
                    cpu_ack <= 1'b1;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    cpu_ack <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
